// File: rtl/led_chaser_pwm_core.sv
// led_chaser_pwm_core: mapped LED chaser with wrap/ping-pong stepping and PWM comet tail; define LINEAR_FADE_EN for linear tail fade
module led_chaser_pwm_core #(
   parameter int NUM_CH = 7,
   parameter int SEQ_LEN = 8,
   parameter int IDX_W = 3,
   parameter logic [SEQ_LEN*IDX_W-1:0] SEQ_MAP = {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0},
   parameter int STEP_CNT_W = 23,
   parameter int FADE_DIV_W = 22,
   parameter int BRIGHT_W = 4,
   localparam int POS_W = $clog2(SEQ_LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        speed,
   input  logic              direction,
   input  logic              pingpong,
   input  logic              tail,
   input  logic              invert,
   output logic [NUM_CH-1:0] led_out,
   output logic              step_pulse,
   output logic [POS_W-1:0]  step_idx
);
   localparam logic [POS_W-1:0] LAST = POS_W'(SEQ_LEN - 1);
   localparam logic [BRIGHT_W-1:0] MAX = {BRIGHT_W{1'b1}};
   logic [2:0] speed_q;
   logic direction_q, pingpong_q, tail_q, invert_q;
   logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic [STEP_CNT_W:0] step_lim;
   logic step, up, at_end;
   logic [POS_W-1:0] pos_q, pos_d;
   logic bounce_q, bounce_d;
   logic [BRIGHT_W-1:0] bright_q [NUM_CH];
   logic [BRIGHT_W-1:0] bright_d [NUM_CH];
   logic [BRIGHT_W-1:0] pwm_cnt_q;
   logic [FADE_DIV_W-1:0] fade_cnt_q;
   logic [IDX_W-1:0] head_ch;
   logic [NUM_CH-1:0] led_raw, led_q;
   logic step_pulse_q;

   function automatic logic [BRIGHT_W-1:0] fade(input logic [BRIGHT_W-1:0] b);
`ifdef LINEAR_FADE_EN
      return (b == '0) ? '0 : b - BRIGHT_W'(1);
`else
      return b >> 1;
`endif
   endfunction

   assign step_lim = (((STEP_CNT_W+1)'(speed_q) + (STEP_CNT_W+1)'(1)) << (STEP_CNT_W - 3)) - (STEP_CNT_W+1)'(1);
   assign step = (STEP_CNT_W+1)'(step_cnt_q) >= step_lim;
   assign head_ch = SEQ_MAP[pos_q*IDX_W +: IDX_W];

   // step timer and head position: >= lets a shrinking period step immediately
   always_comb begin
      step_cnt_d = step ? '0 : step_cnt_q + STEP_CNT_W'(1);
      up = pingpong_q ? bounce_q : direction_q;
      at_end = up ? pos_q == LAST : pos_q == '0;
      pos_d = !step ? pos_q :
              (at_end && pingpong_q) ? (up ? LAST - POS_W'(1) : POS_W'(1)) :
              at_end ? (up ? '0 : LAST) :
              up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      bounce_d = (step && pingpong_q && at_end) ? ~bounce_q : bounce_q;
   end

   // brightness: head forced to max, others fade on the prescaler tick or clear without tail
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         bright_d[c] = (head_ch == IDX_W'(c)) ? MAX :
                       !tail_q ? '0 :
                       (fade_cnt_q == '0) ? fade(bright_q[c]) : bright_q[c];
         led_raw[c] = bright_q[c] > pwm_cnt_q;
      end
   end

   // all state, with input capture and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         {speed_q, direction_q, pingpong_q, tail_q, invert_q} <= '0;
         step_cnt_q <= '0;
         pos_q <= '0;
         bounce_q <= 1'b1;
         pwm_cnt_q <= '0;
         fade_cnt_q <= '0;
         led_q <= '0;
         step_pulse_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) bright_q[c] <= '0;
      end else begin
         {speed_q, direction_q, pingpong_q, tail_q, invert_q} <= {speed, direction, pingpong, tail, invert};
         step_cnt_q <= step_cnt_d;
         pos_q <= pos_d;
         bounce_q <= bounce_d;
         pwm_cnt_q <= pwm_cnt_q + BRIGHT_W'(1);
         fade_cnt_q <= fade_cnt_q + FADE_DIV_W'(1);
         led_q <= led_raw ^ {NUM_CH{invert_q}};
         step_pulse_q <= step;
         for (int c = 0; c < NUM_CH; c++) bright_q[c] <= bright_d[c];
      end
   end

   assign led_out = led_q;
   assign step_pulse = step_pulse_q;
   assign step_idx = pos_q;
endmodule

// File: tb/tb_led_chaser_pwm_core.sv
// tb_led_chaser_pwm_core: directed checks of stepping, mapping, fade tail, invert and reset
module tb_led_chaser_pwm_core;
   logic clk = 1'b0, reset = 1'b1;
   logic [2:0] speed = 3'd0;
   logic direction = 1'b1, pingpong = 1'b0, tail = 1'b0, invert = 1'b0;
   logic [6:0] led_out;
   logic step_pulse;
   logic [2:0] step_idx;
   int n_tests = 0, n_fail = 0;
   int map [8] = '{0, 1, 6, 4, 3, 2, 6, 5};
   int pp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
   logic [6:0] trace [34];
   int cnt [4][7];

   led_chaser_pwm_core #(.STEP_CNT_W(6), .FADE_DIV_W(3), .BRIGHT_W(3)) dut (
      .clk(clk), .reset(reset), .speed(speed), .direction(direction), .pingpong(pingpong),
      .tail(tail), .invert(invert), .led_out(led_out), .step_pulse(step_pulse), .step_idx(step_idx)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick;
      check("rst_led", 32'(led_out), 0);
      check("rst_pulse", 32'(step_pulse), 0);
      check("rst_idx", 32'(step_idx), 0);
      reset = 1'b0;
   endtask

   task automatic step_chk(input int exp_idx, input int prev_pos);
      int n;
      logic [6:0] m;
      n = 0;
      m = '0;
      do begin
         tick;
         n++;
         if (n >= 2) m |= led_out;
      end while (!step_pulse && n < 100);
      check("period", n, 8);
      check("idx", 32'(step_idx), exp_idx);
      check("head", 32'(m), 32'(1) << map[prev_pos]);
   endtask

   initial begin
      logic [6:0] e, m;
      do_reset(2);
      for (int k = 1; k <= 8; k++) step_chk(k % 8, k - 1);
      direction = 1'b0;
      step_chk(7, 0);
      step_chk(6, 7);
      speed = 3'd3;
      repeat (20) tick;
      check("slow", 32'(step_pulse), 0);
      speed = 3'd0;
      tick;
      check("shrink0", 32'(step_pulse), 0);
      tick;
      check("shrink1", 32'(step_pulse), 1);
      check("shrink_idx", 32'(step_idx), 5);
      direction = 1'b1;
      pingpong = 1'b1;
      do_reset(1);
      for (int i = 0; i < 15; i++) step_chk(pp[i+1], pp[i]);
      pingpong = 1'b0;
      tail = 1'b1;
      do_reset(1);
      for (int n = 1; n <= 33; n++) begin
         tick;
         trace[n] = led_out;
         if (n >= 2) for (int c = 0; c < 7; c++) cnt[(n-2)/8][c] += int'(led_out[c]);
      end
      check("head_w0", cnt[0][0], 7);
      check("head_w1", cnt[1][1], 7);
      check("head_w2", cnt[2][6], 7);
      check("head_w3", cnt[3][4], 7);
`ifdef LINEAR_FADE_EN
      check("ch0_w1", cnt[1][0], 6);
      check("ch0_w2", cnt[2][0], 5);
      check("ch0_w3", cnt[3][0], 4);
      check("ch1_w2", cnt[2][1], 6);
      check("ch6_w3", cnt[3][6], 6);
`else
      check("ch0_w1", cnt[1][0], 3);
      check("ch0_w2", cnt[2][0], 1);
      check("ch0_w3", cnt[3][0], 0);
      check("ch1_w2", cnt[2][1], 3);
      check("ch6_w3", cnt[3][6], 3);
`endif
      invert = 1'b1;
      do_reset(1);
      for (int n = 1; n <= 33; n++) begin
         tick;
         e = (n == 1) ? 7'd0 : ~trace[n];
         check("inv", 32'(led_out), 32'(e));
      end
      invert = 1'b0;
      do_reset(1);
      repeat (42) tick;
      check("pre_idx", 32'(step_idx), 5);
      reset = 1'b1;
      tick;
      check("mid_rst_idx", 32'(step_idx), 0);
      check("mid_rst_pulse", 32'(step_pulse), 0);
      check("mid_rst_led", 32'(led_out), 0);
      reset = 1'b0;
      tick;
      check("no_tail", 32'(led_out), 0);
      m = '0;
      repeat (7) begin
         tick;
         m |= led_out;
      end
      check("post_head", 32'(m), 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
